// File: rtl/fetch_buffer_pkg.sv
// Shared core package for the fetch path: the canonical NOP encoding and the
// fetch entry layout for the 32-bit core.
package fetch_buffer_pkg;

    // addi x0, x0, 0 -- presented to decode whenever no real entry is available
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // PC width of the core that this package describes
    localparam int unsigned CORE_XLEN = 32;

    // One queued fetch: PC plus instruction word
    typedef struct packed {
        logic [CORE_XLEN-1:0] pc;
        logic [31:0]          instr;
    } fetch_entry_t;

endpackage : fetch_buffer_pkg

// File: rtl/fetch_buffer.sv
// Fetch buffer: circular queue of fetched (pc, instr) entries between fetch and
// decode, with valid/ready handshakes on both sides and a flush for redirects.
// Optional feature: define FETCH_BUFFER_BYPASS_EN to let an entry arriving at
// an empty buffer reach decode in the same cycle.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_instr,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Local entry layout follows the XLEN parameter rather than the package width
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [XLEN-1:0]    pc_hold_q, pc_hold_d;

    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    entry_t             head;

    assign count = count_q;

    // Handshake decode, head presentation and next-state pointer/count logic
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        head      = mem_q[rd_ptr_q];

        // A full buffer never accepts, even if decode pops this cycle
        in_ready  = !full && !flush;

        out_valid = !empty;
        out_pc    = empty ? pc_hold_q : head.pc;
        out_instr = empty ? NOP_INSTR : head.instr;

        pop       = !empty && out_ready && !flush;
        push      = in_valid && in_ready;

`ifdef FETCH_BUFFER_BYPASS_EN
        // Empty buffer: forward the incoming entry straight to decode; it is
        // only stored if decode does not take it this cycle.
        if (empty && in_valid && !flush) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
            if (out_ready) begin
                push = 1'b0;
            end
        end
`endif

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        // out_pc keeps the last PC shown to decode while the buffer is empty
        pc_hold_d = out_valid ? out_pc : pc_hold_q;
    end

    // Control state register with synchronous reset overriding everything
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pc_hold_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pc_hold_q <= pc_hold_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
        end
    end

endmodule : fetch_buffer

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer (DEPTH=4, XLEN=32). Accepted pushes queue
// their expected entry; a negedge monitor pops and compares on every handshake.
module tb_fetch_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        flush;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .flush    (flush),
        .count    (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = 32'hA000_0000 | pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic expect_entry(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'hA000_0000 | pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every decode handshake must match the oldest expected entry
    always @(negedge clock) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got pc %0h expected no entry (t=%0t)", out_pc, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_pc", {32'h0, out_pc}, {32'h0, e.pc});
                check("pop_instr", {32'h0, out_instr}, {32'h0, e.instr});
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;

        // Idle after reset
        @(negedge clock);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_out_instr", {32'h0, out_instr}, 64'h13);
        check("rst_count", {61'h0, count}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);

        // Fill to DEPTH with decode stalled
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            expect_entry(32'(i * 4));
            step();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        @(negedge clock);
        check("full_count", {61'h0, count}, 64'h4);
        check("full_in_ready", {63'h0, in_ready}, 64'h0);
        step();
        check("reject_count", {61'h0, count}, 64'h4);

        // Full plus simultaneous pop still refuses the push
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        @(negedge clock);
        check("full_pop_in_ready", {63'h0, in_ready}, 64'h0);
        step();
        check("full_pop_count", {61'h0, count}, 64'h3);

        // Drain the rest
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        @(negedge clock);
        check("drain_count", {61'h0, count}, 64'h0);
        check("drain_out_valid", {63'h0, out_valid}, 64'h0);
        check("drain_nop", {32'h0, out_instr}, 64'h13);
        check("drain_pc_hold", {32'h0, out_pc}, 64'hC);
        step();

        // Interleaved push/pop across the pointer wrap
        for (int k = 0; k < 8; k++) begin
            drive(k < 6, 32'h200 + 32'(k * 4), k >= 1, 1'b0);
            if (k < 6) expect_entry(32'h200 + 32'(k * 4));
            @(negedge clock);
            check("wrap_count_le4", {63'h0, count <= 3'd4}, 64'h1);
            step();
        end
        check("wrap_count_end", {61'h0, count}, 64'h0);
        check("wrap_sb_empty", 64'(exp_q.size()), 64'h0);

        // Flush with 3 queued, push and pop both offered
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h30C, 1'b1, 1'b1);
        @(negedge clock);
        check("flush_in_ready", {63'h0, in_ready}, 64'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("flush_count", {61'h0, count}, 64'h0);
        check("flush_out_valid", {63'h0, out_valid}, 64'h0);
        check("flush_nop", {32'h0, out_instr}, 64'h13);

        // Flush held for two cycles with pushes offered keeps it empty
        step();
        drive(1'b1, 32'h400, 1'b0, 1'b1);
        step();
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("flush_hold_count", {61'h0, count}, 64'h0);

        // Reset while full with a push offered
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
            step();
        end
        reset = 1'b1;
        drive(1'b1, 32'h510, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("rst_full_count", {61'h0, count}, 64'h0);
        check("rst_full_nop", {32'h0, out_instr}, 64'h13);
        check("rst_full_out_valid", {63'h0, out_valid}, 64'h0);

        // Push into empty buffer with decode ready: latency check
        step();
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        expect_entry(32'h100);
`ifdef FETCH_BUFFER_BYPASS_EN
        @(negedge clock);
        check("byp_out_valid", {63'h0, out_valid}, 64'h1);
        check("byp_out_pc", {32'h0, out_pc}, 64'h100);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clock);
        check("byp_count", {61'h0, count}, 64'h0);
`else
        @(negedge clock);
        check("lat_out_valid_same", {63'h0, out_valid}, 64'h0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clock);
        check("lat_out_valid_next", {63'h0, out_valid}, 64'h1);
        check("lat_out_pc_next", {32'h0, out_pc}, 64'h100);
        step();
        @(negedge clock);
        check("lat_count", {61'h0, count}, 64'h0);
`endif
        step();
        check("final_sb_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_buffer

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL take parameter DEPTH, default 4, meaning the number of queued fetch entries; legal values are powers of two, 2..64.
REQ-002 SHALL take parameter XLEN, default 32, meaning the PC width in bits.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the fetch stage presents an entry.
REQ-006 SHALL have port in_ready, output, 1 bit: the buffer accepts the entry this cycle.
REQ-007 SHALL have port in_pc, input, XLEN bits: the PC of the fetched instruction.
REQ-008 SHALL have port in_instr, input, 32 bits: the fetched instruction word.
REQ-009 SHALL have port out_valid, output, 1 bit: the head entry is valid for decode.
REQ-010 SHALL have port out_ready, input, 1 bit: decode consumes the head entry (the inverse of the decode stall).
REQ-011 SHALL have port out_pc, output, XLEN bits: the head PC.
REQ-012 SHALL have port out_instr, output, 32 bits: the head instruction.
REQ-013 SHALL have port flush, input, 1 bit: a branch/jump redirect from execute that discards all entries.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-015 Storage SHALL be a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 A push SHALL occur on a clock edge when in_valid && in_ready.
REQ-017 A pop SHALL occur on a clock edge when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != DEPTH) && !flush; a full buffer SHALL NOT accept, even with a simultaneous pop.
REQ-019 out_valid SHALL equal (count != 0), except as given in REQ-028.
REQ-020 When out_valid=0, out_instr SHALL be 32'h00000013 (NOP) and out_pc SHALL hold its last value.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Push-to-out_valid latency SHALL be 1 cycle; an entry is never visible in the cycle it is pushed, except as given in REQ-028.
REQ-023 Entries SHALL leave in push order; no entry is duplicated or lost except by flush.
REQ-024 On flush=1, the next edge SHALL zero both pointers and count; any same-cycle push or pop SHALL be ignored.
REQ-025 flush SHALL take priority over push and pop; flush held for multiple cycles keeps the buffer empty.
REQ-026 When out_valid=0, out_ready SHALL have no effect.

Reset
REQ-027 On reset=1 at an edge: pointers=0, count=0, out_valid=0, out_instr=NOP; reset SHALL override flush, push and pop; reset mid-stream discards all entries.

Configuration
REQ-028 With macro FETCH_BUFFER_BYPASS_EN defined, when count==0 && in_valid && !flush: out_valid SHALL be 1 combinationally, out_pc/out_instr SHALL equal in_pc/in_instr, and if out_ready=1 the entry SHALL NOT be written (0-cycle latency); if out_ready=0 it SHALL be pushed normally.
REQ-029 Without FETCH_BUFFER_BYPASS_EN, there SHALL be no combinational path from in_* to out_*; latency is fixed at 1 cycle.

Structure
REQ-030 The NOP_INSTR constant (32'h00000013) SHALL live in the shared core package, alongside a fetch entry struct typedef {pc[XLEN], instr[32]}.
REQ-031 The block SHALL be a single module with no sub-module; the storage array and pointer logic are inline.

Verification
REQ-032 Reset, then idle: out_valid=0, out_instr=32'h00000013, count=0, in_ready=1.
REQ-033 DEPTH=4, push PCs 0x0,0x4,0x8,0xC with out_ready=0: count=4, in_ready=0; a fifth push of 0x10 is rejected; popping returns 0x0,0x4,0x8,0xC in order.
REQ-034 Push 6 and pop 6 interleaved (wrap-around): output order matches the input order, count never exceeds 4, and count returns to 0.
REQ-035 With 3 entries queued, assert flush while in_valid=1 and out_ready=1: next cycle count=0, out_valid=0, no entry popped or pushed.
REQ-036 Assert reset while full and in_valid=1: next cycle count=0 and out_instr=NOP.
REQ-037 With FETCH_BUFFER_BYPASS_EN, empty buffer, in_pc=0x100, out_ready=1: same cycle out_valid=1 and out_pc=0x100; next cycle count=0. Without the macro, out_valid rises one cycle later.
